uart_img_loader: RTL
====================

Name: uart_img_loader

Overview:
- Upstream image source for the single-port image BRAM, ahead of memory_controller.
- Receives a raw 8-bit grayscale frame over a UART line, MAX_ROW x MAX_COL bytes in raster order.
- Writes each received byte to consecutive BRAM addresses starting at 0.
- Flags completion so the controller can start mode1/mode2 processing.

Parameters:
CLKS_PER_BIT, 43, clk_10 cycles per UART bit (5 MHz / 115200 baud, rounded); must be >= 4
MAX_ROW, 360, image rows
MAX_COL, 540, image columns
ADDR_W, 18, BRAM address width; must satisfy 2^ADDR_W >= MAX_ROW*MAX_COL

Ports:
clk_10  input  1  system clock for this block
rst_n  input  1  reset; asynchronous assert, active-low
uart_rx_i  input  1  asynchronous UART RX line, idle high, 8N1, LSB first
load_start_i  input  1  level from switch/controller; a rising edge arms a new frame load
ena_o  output  1  BRAM enable, one-cycle pulse per written byte
wea_o  output  1  BRAM write enable, equal to ena_o
addr_o  output  ADDR_W  BRAM write address
d2mem_o  output  8  BRAM write data
load_busy_o  output  1  high while a frame load is in progress
load_done_o  output  1  high from completion of a full frame until the next load is armed
frame_err_o  output  1  sticky stop-bit error flag; cleared when a load is armed
byte_cnt_o  output  ADDR_W  number of bytes written in the current load

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs return 0.
  - All FSMs go to their IDLE state.
  - Synchronizer flops reset to 1.
  - Reset mid-load abandons the frame; BRAM contents are left as-is.
- Input conditioning:
  - uart_rx_i passes through a 2-flop synchronizer.
  - load_start_i passes through a 2-flop synchronizer followed by an edge detector.
  - A rising edge produces a one-cycle arm pulse 3 cycles after the input edge.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a synchronized rx low moves to R_START and clears the bit counter.
  - R_START: wait CLKS_PER_BIT/2 (integer division) cycles, then sample rx.
    - rx low: go to R_DATA.
    - rx high: glitch; return to R_IDLE with no error.
  - R_DATA: sample every CLKS_PER_BIT cycles, shifting right (LSB first). After 8 samples go to R_STOP.
  - R_STOP: after CLKS_PER_BIT cycles, sample rx.
    - rx high: assert rx_valid (internal) for exactly 1 cycle with the byte.
    - rx low: set frame_err_o (only while load_busy_o=1) and discard the byte.
    - Either outcome returns to R_IDLE.
  - Back-to-back bytes with no idle gap are accepted.
- Loader FSM states: L_IDLE, L_LOAD, L_DONE.
  - Arm pulse in any state:
    - addr and byte_cnt_o set to 0; load_done_o and frame_err_o cleared; load_busy_o set to 1.
    - Go to L_LOAD on the next cycle.
    - An arm during L_LOAD restarts the frame at address 0.
    - If arm and rx_valid coincide, the arm wins and the byte is discarded.
  - L_LOAD, on rx_valid:
    - Next cycle: ena_o=wea_o=1 for exactly one cycle, addr_o=current address, d2mem_o=byte.
    - The address then increments and byte_cnt_o increments.
    - Write latency: 1 cycle after rx_valid, i.e. 1 cycle after the stop-bit mid-sample.
  - Completion: when the write to address MAX_ROW*MAX_COL-1 issues:
    - Next cycle: load_busy_o=0, load_done_o=1, go to L_DONE.
    - byte_cnt_o holds MAX_ROW*MAX_COL.
  - L_IDLE and L_DONE: received bytes are ignored, with no BRAM access. The address never wraps.
- Output stability:
  - addr_o and d2mem_o hold their last value when ena_o=0.
  - byte_cnt_o is stable except on write cycles and arm.

Test Plan:
- Sim overrides for all cases: CLKS_PER_BIT=4, MAX_ROW=2, MAX_COL=3.
- Reset then idle line, no arm -> all outputs 0; load_busy_o=load_done_o=0 indefinitely.
- Arm, then send bytes 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back:
  - Six single-cycle ena_o/wea_o pulses at addr 0..5 with matching data.
  - load_done_o=1 and byte_cnt_o=6 one cycle after the last write.
  - A 7th byte 0x77 produces no write.
- Send 0xA5 with no arm -> no ena_o pulse, frame_err_o=0.
- Arm, then send a byte with stop bit held low:
  - No write, frame_err_o=1, byte_cnt_o unchanged.
  - A following valid 0x3C is written at addr 0.
  - A new arm clears frame_err_o.
- 1-cycle low glitch (shorter than CLKS_PER_BIT/2) during L_LOAD -> no write, no error.
- Arm, write 3 bytes, re-arm, send 1 byte -> that byte is written at addr 0, byte_cnt_o=1, load_done_o=0.
- Assert rst_n low mid-byte during L_LOAD -> outputs 0 asynchronously; after release, a new arm loads from addr 0.

Source files
------------

// File: rtl/uart_img_loader.sv
// UART 8N1 receiver that streams one raw grayscale frame into the image BRAM from address 0.
// Latency: BRAM write one cycle after the stop-bit sample; arm takes effect 4 cycles after the load_start edge.
// No backpressure: the line cannot be stalled, so bytes that arrive outside a load are dropped.
`timescale 1ns/1ps
module uart_img_loader #(
  parameter int CLKS_PER_BIT = 43,
  parameter int MAX_ROW      = 360,
  parameter int MAX_COL      = 540,
  parameter int ADDR_W       = 18
) (
  input  logic              clk_10,
  input  logic              rst_n,
  input  logic              uart_rx_i,
  input  logic              load_start_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        d2mem_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              frame_err_o,
  output logic [ADDR_W-1:0] byte_cnt_o
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MAX_ROW * MAX_COL - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;

  logic rx_s1, rx_s2;
  logic ld_s1, ld_s2, ld_d;
  logic arm;

  rx_state_t        rx_st;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             rx_vld;
  logic [7:0]       rx_dat;
  logic             rx_err;

  ld_state_t        ld_st;

  // Sync flops idle high so a line or switch already high at reset does not look like an edge.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      ld_s1 <= 1'b1;
      ld_s2 <= 1'b1;
      ld_d  <= 1'b1;
      arm   <= 1'b0;
    end else begin
      rx_s1 <= uart_rx_i;
      rx_s2 <= rx_s1;
      ld_s1 <= load_start_i;
      ld_s2 <= ld_s1;
      ld_d  <= ld_s2;
      arm   <= ld_s2 & ~ld_d;
    end
  end

  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= R_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_vld  <= 1'b0;
      rx_dat  <= '0;
      rx_err  <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      rx_err <= 1'b0;
      case (rx_st)
        R_IDLE: begin
          if (!rx_s2) begin
            rx_st   <= R_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        R_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            rx_st   <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_st <= R_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            rx_st   <= R_IDLE;
            if (rx_s2) begin
              rx_vld <= 1'b1;
              rx_dat <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // byte_cnt_o doubles as the next write address; it only advances inside a load, so it never wraps.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      ld_st       <= L_IDLE;
      ena_o       <= 1'b0;
      wea_o       <= 1'b0;
      addr_o      <= '0;
      d2mem_o     <= '0;
      load_busy_o <= 1'b0;
      load_done_o <= 1'b0;
      frame_err_o <= 1'b0;
      byte_cnt_o  <= '0;
    end else begin
      ena_o <= 1'b0;
      wea_o <= 1'b0;
      if (arm) begin
        ld_st       <= L_LOAD;
        addr_o      <= '0;
        byte_cnt_o  <= '0;
        load_busy_o <= 1'b1;
        load_done_o <= 1'b0;
        frame_err_o <= 1'b0;
      end else begin
        if (rx_err && load_busy_o) frame_err_o <= 1'b1;
        if (ld_st == L_LOAD) begin
          if (ena_o && addr_o == LAST) begin
            ld_st       <= L_DONE;
            load_busy_o <= 1'b0;
            load_done_o <= 1'b1;
          end else if (rx_vld) begin
            ena_o      <= 1'b1;
            wea_o      <= 1'b1;
            addr_o     <= byte_cnt_o;
            d2mem_o    <= rx_dat;
            byte_cnt_o <= byte_cnt_o + 1'b1;
          end
        end
      end
    end
  end

endmodule
